// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: op_sel mnemonics, MIPS opcode/funct
// constants, FSM states and field-packing helpers.
package instr_encoder_pkg;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,  OP_ADDU  = 5'd1,  OP_SUBU = 5'd2,  OP_AND  = 5'd3,
        OP_OR    = 5'd4,  OP_SLT   = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,
        OP_MULTU = 5'd8,  OP_MFHI  = 5'd9,  OP_MFLO = 5'd10, OP_LW   = 5'd11,
        OP_SW    = 5'd12, OP_BEQ   = 5'd13, OP_BGTZ = 5'd14, OP_J    = 5'd15,
        OP_ADDIU = 5'd16, OP_ORI   = 5'd17
    } op_sel_e;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_J     = 6'd2;
    localparam logic [5:0] OPC_BEQ   = 6'd4;
    localparam logic [5:0] OPC_BGTZ  = 6'd7;
    localparam logic [5:0] OPC_ADDIU = 6'd9;
    localparam logic [5:0] OPC_ORI   = 6'd13;
    localparam logic [5:0] OPC_LW    = 6'd35;
    localparam logic [5:0] OPC_SW    = 6'd43;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Beat channel from an instruction-description source into the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (output in_valid, in_last, op_sel, rs, rt, rd, shamt, imm, target,
                    input  in_ready);
    modport slave  (input  in_valid, in_last, op_sel, rs, rt, rd, shamt, imm, target,
                    output in_ready);
endinterface

// File: rtl/instr_field_pack.sv
// Combinational mnemonic + fields -> 32-bit MIPS word; unused fields are forced to zero.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel)
            OP_NOP:   word = '0;
            OP_ADDU:  word = rtype(rs, rt, rd, 5'd0, FN_ADDU);
            OP_SUBU:  word = rtype(rs, rt, rd, 5'd0, FN_SUBU);
            OP_AND:   word = rtype(rs, rt, rd, 5'd0, FN_AND);
            OP_OR:    word = rtype(rs, rt, rd, 5'd0, FN_OR);
            OP_SLT:   word = rtype(rs, rt, rd, 5'd0, FN_SLT);
            OP_SLL:   word = rtype(5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:   word = rtype(5'd0, rt, rd, shamt, FN_SRL);
            OP_MULTU: word = rtype(rs, rt, 5'd0, 5'd0, FN_MULTU);
            OP_MFHI:  word = rtype(5'd0, 5'd0, rd, 5'd0, FN_MFHI);
            OP_MFLO:  word = rtype(5'd0, 5'd0, rd, 5'd0, FN_MFLO);
            OP_LW:    word = itype(OPC_LW, rs, rt, imm);
            OP_SW:    word = itype(OPC_SW, rs, rt, imm);
            OP_BEQ:   word = itype(OPC_BEQ, rs, rt, imm);
            OP_BGTZ:  word = itype(OPC_BGTZ, rs, 5'd0, imm);
            OP_J:     word = {OPC_J, target};
            OP_ADDIU: word = itype(OPC_ADDIU, rs, rt, imm);
            OP_ORI:   word = itype(OPC_ORI, rs, rt, imm);
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Burst loader: encodes one instruction per accepted beat and writes it to
// instruction memory the following cycle at consecutive word addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [$clog2(DEPTH)-1:0] base_addr,
    instr_encoder_if.slave           bus,
    output logic                     im_we,
    output logic [$clog2(DEPTH)+1:0] im_addr,
    output logic [31:0]              im_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     wrap,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    state_e          state;
    logic            ready;
    logic [AW-1:0]   idx;
    logic [31:0]     word;
    logic            illegal;
    logic            accept;

    instr_field_pack u_pack (
        .op_sel  (bus.op_sel),
        .rs      (bus.rs),
        .rt      (bus.rt),
        .rd      (bus.rd),
        .shamt   (bus.shamt),
        .imm     (bus.imm),
        .target  (bus.target),
        .word    (word),
        .illegal (illegal)
    );

    assign bus.in_ready = ready;
    assign accept       = bus.in_valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ready    <= 1'b0;
            idx      <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wrap     <= 1'b0;
            count    <= '0;
        end else begin
            im_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state <= ST_LOAD;
                    ready <= 1'b1;
                    busy  <= 1'b1;
                    idx   <= base_addr;
                    count <= '0;
                    err   <= 1'b0;
                    wrap  <= 1'b0;
                end
                ST_LOAD: if (accept) begin
                    im_we    <= 1'b1;
                    im_addr  <= {idx, 2'b00};
                    im_wdata <= word;
                    idx      <= idx + 1'b1;
                    if (count != CNT_MAX) count <= count + 1'b1;
                    if (illegal) err <= 1'b1;
                    // Index 0 after an earlier write in this burst means we rolled over.
                    if (count != '0 && idx == '0) wrap <= 1'b1;
                    if (bus.in_last) begin
                        state <= ST_DRAIN;
                        ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, addresses and status flags.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          im_we;
    logic [AW+1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy, done, err, wrap;
    logic [AW:0]   count;

    int tests = 0;
    int fails = 0;

    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wrap      (wrap),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                            input logic [25:0] tgt, input logic last);
        bus.in_valid = 1'b1;
        bus.op_sel   = op;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd       = rd;
        bus.shamt    = sh;
        bus.imm      = imm;
        bus.target   = tgt;
        bus.in_last  = last;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
        check("start_ready", 32'(bus.in_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_we"}, 32'(im_we), 32'd1);
        check({tag, "_addr"}, 32'(im_addr), addr);
        check({tag, "_data"}, im_wdata, data);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        tick();
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.op_sel = '0;
        bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.shamt = '0;
        bus.imm = '0; bus.target = '0;

        // Reset state
        tick(); tick();
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_addr", 32'(im_addr), 32'd0);
        check("rst_data", im_wdata, 32'd0);
        check("rst_flags", {busy, done, err, wrap}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single ADDU with in_last on the first beat
        do_start(8'd0);
        set_beat(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
        tick();
        idle_in();
        chk_wr("addu", 32'h0, 32'h0022_1821);
        check("addu_ready_drop", 32'(bus.in_ready), 32'd0);
        check("addu_count", 32'(count), 32'd1);
        wait_done();
        check("addu_count_hold", 32'(count), 32'd1);

        // Three-beat burst at full rate
        do_start(8'd0);
        set_beat(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
        tick();
        chk_wr("lw", 32'h0, 32'h8FA8_0004);
        set_beat(OP_SLL, 5'd9, 5'd5, 5'd4, 5'd2, 16'd0, 26'd0, 1'b0);
        tick();
        chk_wr("sll", 32'h4, 32'h0005_2080);
        set_beat(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000, 1'b1);
        tick();
        idle_in();
        chk_wr("j", 32'h8, 32'h0810_0000);
        check("burst3_count", 32'(count), 32'd3);
        wait_done();

        // Illegal op mid-burst: zero word, sticky err
        do_start(8'd4);
        set_beat(OP_ADDIU, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0);
        tick();
        chk_wr("addiu", 32'h10, 32'h2422_1234);
        check("addiu_err", 32'(err), 32'd0);
        set_beat(5'd25, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
        tick();
        chk_wr("illegal", 32'h14, 32'h0);
        check("illegal_err", 32'(err), 32'd1);
        set_beat(OP_ORI, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b1);
        tick();
        idle_in();
        chk_wr("ori", 32'h18, 32'h3464_FFFF);
        wait_done();
        check("err_hold", 32'(err), 32'd1);

        // Wrap at the top of memory
        do_start(8'd255);
        check("start_clears_err", 32'(err), 32'd0);
        set_beat(OP_NOP, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'd0, 1'b0);
        tick();
        chk_wr("nop_top", 32'h3FC, 32'h0);
        check("wrap_before", 32'(wrap), 32'd0);
        set_beat(OP_BGTZ, 5'd7, 5'd9, 5'd0, 5'd0, 16'h0010, 26'd0, 1'b1);
        tick();
        idle_in();
        chk_wr("bgtz_wrap", 32'h0, 32'h1CE0_0010);
        check("wrap_set", 32'(wrap), 32'd1);
        check("wrap_count", 32'(count), 32'd2);
        wait_done();
        check("wrap_hold", 32'(wrap), 32'd1);

        // Gapped valid, start pulses while busy ignored
        do_start(8'd10);
        check("start_clears_wrap", 32'(wrap), 32'd0);
        set_beat(OP_SW, 5'd2, 5'd3, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
        tick();
        chk_wr("sw", 32'h28, 32'hAC43_0008);
        idle_in();
        start = 1'b1; base_addr = 8'd100;
        tick();
        check("gap1_we", 32'(im_we), 32'd0);
        set_beat(OP_MULTU, 5'd1, 5'd2, 5'd9, 5'd3, 16'd0, 26'd0, 1'b0);
        tick();
        start = 1'b0;
        chk_wr("multu", 32'h2C, 32'h0022_0019);
        idle_in();
        tick();
        check("gap2_we", 32'(im_we), 32'd0);
        set_beat(OP_MFHI, 5'd7, 5'd8, 5'd5, 5'd1, 16'd0, 26'd0, 1'b1);
        tick();
        idle_in();
        chk_wr("mfhi", 32'h30, 32'h0000_2810);
        check("gap_count", 32'(count), 32'd3);
        wait_done();

        // Reset mid-burst abandons the write
        do_start(8'd0);
        set_beat(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(im_we), 32'd0);
        check("mid_rst_addr_data", 32'(im_addr) | im_wdata, 32'd0);
        check("mid_rst_flags", {bus.in_ready, busy, done, err, wrap}, 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        tick();
        idle_in();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_we", 32'(im_we), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        do_start(8'd3);
        set_beat(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0040, 1'b1);
        tick();
        idle_in();
        chk_wr("restart_j", 32'hC, 32'h0800_0040);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 256, instruction-memory depth in words (power of two).
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst_n  in  1  one clock; reset is asynchronous and active-low.
REQ-004 start  in  1  one-cycle pulse; opens a load burst at base_addr.
REQ-005 base_addr  in  log2(DEPTH)  first word index of the burst.
REQ-006 in_valid  in  1  source holds a valid instruction description.
REQ-007 in_ready  out  1  encoder accepts a beat this cycle.
REQ-008 in_last  in  1  qualifies the final beat of the burst.
REQ-009 op_sel  in  5  mnemonic: 0 NOP, 1 ADDU, 2 SUBU, 3 AND, 4 OR, 5 SLT, 6 SLL, 7 SRL, 8 MULTU, 9 MFHI, 10 MFLO, 11 LW, 12 SW, 13 BEQ, 14 BGTZ, 15 J, 16 ADDIU, 17 ORI; 18-31 illegal.
REQ-010 rs, rt, rd, shamt  in  5 each  register/shift fields.
REQ-011 imm  in  16  immediate/offset; target  in  26  jump target.
REQ-012 im_we  out  1  instruction-memory write strobe.
REQ-013 im_addr  out  log2(DEPTH)+2  byte address {word_index,2'b00}.
REQ-014 im_wdata  out  32  encoded instruction word.
REQ-015 busy  out  1; done  out  1 (one-cycle pulse); err  out  1 (sticky); wrap  out  1 (sticky); count  out  log2(DEPTH)+1  words written this burst.

Function
REQ-016 FSM states IDLE, LOAD, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE: start -> LOAD, word index := base_addr, count := 0, err := 0, wrap := 0.
REQ-018 LOAD: in_ready = 1; beat accepted when in_valid & in_ready; accepted beat with in_last -> DRAIN.
REQ-019 DRAIN: in_ready = 0, final write completes -> DONE; DONE: done = 1 for one cycle -> IDLE.
REQ-020 busy = 1 in LOAD, DRAIN, DONE; start ignored unless IDLE.
REQ-021 Latency: word of beat accepted in cycle N appears with im_we = 1 in cycle N+1; one write per accepted beat, back-to-back at full rate.
REQ-022 R-type (ADDU/SUBU/AND/OR/SLT/SLL/SRL/MULTU/MFHI/MFLO): opcode 0, funct 33/35/36/37/42/0/2/25/16/18; unused fields forced 0 (shamt 0 except SLL/SRL; rs 0 for SLL/SRL/MFHI/MFLO; rd 0 for MULTU; rs,rt 0 for MFHI/MFLO).
REQ-023 I-type: LW 35, SW 43, BEQ 4, BGTZ 7 (rt forced 0), ADDIU 9, ORI 13; word = {op,rs,rt,imm}.
REQ-024 J: {6'd2,target}; NOP: 32'h0000_0000.
REQ-025 Illegal op_sel: write 32'h0000_0000, set err; burst continues.
REQ-026 Word index increments modulo DEPTH after each write; write at index DEPTH-1 followed by another write sets wrap, next address = 0.
REQ-027 count increments per write, saturates at DEPTH.
REQ-028 in_last on first beat is legal: one write, then DRAIN.
REQ-029 err/wrap/count hold after DONE until next start.

Reset
REQ-030 rst_n low asynchronously forces: IDLE, in_ready 0, im_we 0, im_addr 0, im_wdata 0, busy 0, done 0, err 0, wrap 0, count 0.
REQ-031 Reset mid-burst abandons the pending write (no im_we after reset release); no resume.

Structure
REQ-032 Shared package holds op_sel encodings, opcode and funct constants (shared with control_single decoding) and FSM state type.
REQ-033 One combinational sub-module instr_field_pack (op_sel + fields -> 32-bit word, illegal flag); sequencing in instr_encoder.

Verification
REQ-034 start, base_addr 0; ADDU rs1 rt2 rd3, in_last -> cycle+1 im_we, im_addr 0, im_wdata 0x00221821; done pulse; count 1.
REQ-035 Burst LW rt8 rs29 imm4, SLL rd4 rt5 shamt2, J target 0x0100000 (last), in_valid held -> writes 0x8FA80004 @0, 0x00052080 @4, 0x08100000 @8 on consecutive cycles.
REQ-036 op_sel 25 in mid-burst -> writes 0x00000000, err = 1, burst continues, err cleared only by next start.
REQ-037 DEPTH 256, base_addr 255, two beats -> addresses 0x3FC then 0x000, wrap = 1, count 2.
REQ-038 rst_n low during LOAD with beat just accepted -> im_we stays 0, all outputs 0, state IDLE; new start works normally.
REQ-039 in_valid toggling 1/0 in LOAD -> exactly one write per valid cycle, addresses contiguous; start pulses while busy have no effect.
